// File: rtl/mu_pkg.sv
// Shared types and constants for the measure-unit adder sharing logic.
package mu_pkg;

  localparam int unsigned ADD_W              = 32;
  localparam int unsigned ADD_ISSUE_INTERVAL = 3;
  localparam int unsigned ADD_RESULT_LAT     = 3;
  localparam int unsigned DRAIN_CYCLES       = 3;

  typedef enum logic [2:0] {
    DRAIN,
    IDLE,
    WAIT1,
    WAIT2,
    COLLECT
  } share_state_e;

  typedef struct packed {
    logic [ADD_W-1:0] a;
    logic [ADD_W-1:0] b;
  } add_op_t;

endpackage

// File: rtl/adder_share_ctrl_if.sv
// Requester, adder and response signals of the shared-adder controller.
interface adder_share_ctrl_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
);
  import mu_pkg::*;

  logic [N_REQ-1:0]            req_valid_i;
  logic [N_REQ-1:0][ADD_W-1:0] req_a_i;
  logic [N_REQ-1:0][ADD_W-1:0] req_b_i;
  logic [N_REQ-1:0]            req_ready_o;
  logic                        add_valid_o;
  logic [ADD_W-1:0]            add_a_o;
  logic [ADD_W-1:0]            add_b_o;
  logic [ADD_W-1:0]            add_res_i;
  logic [N_REQ-1:0]            rsp_valid_o;
  logic [ADD_W-1:0]            rsp_res_o;
  logic [ID_W-1:0]             rsp_id_o;
  logic                        busy_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, add_res_i,
    output req_ready_o, add_valid_o, add_a_o, add_b_o,
    output rsp_valid_o, rsp_res_o, rsp_id_o, busy_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, add_res_i,
    input  req_ready_o, add_valid_o, add_a_o, add_b_o,
    input  rsp_valid_o, rsp_res_o, rsp_id_o, busy_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after ptr, wrapping at N.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  // Smallest circular distance from ptr wins.
  always_comb begin
    int best;
    int off;
    grant = '0;
    idx   = '0;
    best  = int'(N);
    off   = 0;
    for (int j = 0; j < int'(N); j++) begin
      if (j >= int'(ptr)) off = j - int'(ptr);
      else                off = j + int'(N) - int'(ptr);
      if (en && req[j] && (off < best)) begin
        best = off;
        idx  = IDX_W'(j);
      end
    end
    if (best < int'(N)) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one two-cycle 32-bit adder between N_REQ requesters on a fixed
// issue/collect schedule, returning each sum tagged with its requester id.
module adder_share_ctrl #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input logic               clk_i,
  input logic               rst_i,
  adder_share_ctrl_if.slave bus
);
  import mu_pkg::*;

  localparam int unsigned DRAIN_CNT_W = $clog2(DRAIN_CYCLES + 1);

  share_state_e           state_q;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q;
  logic [ID_W-1:0]        rr_ptr_q;
  logic [ID_W-1:0]        cur_id_q;
  logic [N_REQ-1:0]       rsp_valid_q;
  logic [ADD_W-1:0]       rsp_res_q;
  logic [ID_W-1:0]        rsp_id_q;

  logic                   can_issue_c;
  logic                   issue_c;
  logic [N_REQ-1:0]       grant_c;
  logic [ID_W-1:0]        grant_idx_c;
  add_op_t                op_c;

  // Reset also masks accepts so no requester sees ready for a dropped op.
  assign can_issue_c = !rst_i && ((state_q == IDLE) || (state_q == COLLECT));

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req   (bus.req_valid_i),
    .ptr   (rr_ptr_q),
    .en    (can_issue_c),
    .grant (grant_c),
    .idx   (grant_idx_c)
  );

  assign issue_c = |grant_c;

  always_comb begin
    op_c = '0;
    if (issue_c) begin
      op_c.a = bus.req_a_i[grant_idx_c];
      op_c.b = bus.req_b_i[grant_idx_c];
    end
  end

  assign bus.req_ready_o = grant_c;
  assign bus.add_valid_o = issue_c;
  assign bus.add_a_o     = op_c.a;
  assign bus.add_b_o     = op_c.b;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_res_o   = rsp_res_q;
  assign bus.rsp_id_o    = rsp_id_q;
  assign bus.busy_o      = (state_q != IDLE);

  // Adder valid_o is not used: the sum is taken on the fixed COLLECT slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= DRAIN;
      drain_cnt_q <= DRAIN_CNT_W'(DRAIN_CYCLES);
      rr_ptr_q    <= '0;
      cur_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_res_q   <= '0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= '0;
      if (issue_c) begin
        cur_id_q <= grant_idx_c;
        rr_ptr_q <= (32'(grant_idx_c) == (N_REQ - 1)) ? '0 : grant_idx_c + ID_W'(1);
      end
      case (state_q)
        DRAIN: begin
          drain_cnt_q <= drain_cnt_q - DRAIN_CNT_W'(1);
          if (drain_cnt_q == DRAIN_CNT_W'(1)) state_q <= IDLE;
        end
        IDLE:    if (issue_c) state_q <= WAIT1;
        WAIT1:   state_q <= WAIT2;
        WAIT2:   state_q <= COLLECT;
        COLLECT: begin
          rsp_res_q   <= bus.add_res_i;
          rsp_id_q    <= cur_id_q;
          rsp_valid_q <= N_REQ'(1) << cur_id_q;
          state_q     <= issue_c ? WAIT1 : IDLE;
        end
        default: state_q <= DRAIN;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Randomised and directed bench for adder_share_ctrl with a transaction-level
// reference model and a split-half two-cycle adder model.
module tb_adder_share_ctrl;
  import mu_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = -1;
  int   n_chk = 0;
  int   n_pass = 0;

  adder_share_ctrl_if #(.N_REQ(N), .ID_W(IW)) bus ();

  adder_share_ctrl #(.N_REQ(N), .ID_W(IW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
  endtask

  // Adder without reset: low half lands one cycle after issue, high half the next.
  logic        smp_v = 1'b0;
  logic [31:0] smp_a = '0, smp_b = '0;
  logic [31:0] ad_a = '0, ad_b = '0, ad_res = '0, ad_sum;
  int          ad_ph = 0;
  assign ad_sum = ad_a + ad_b;
  assign bus.add_res_i = ad_res;

  always @(negedge clk) begin
    smp_v = bus.add_valid_o;
    smp_a = bus.add_a_o;
    smp_b = bus.add_b_o;
  end

  always @(posedge clk) begin
    if (ad_ph == 1) ad_res[15:0]  <= ad_sum[15:0];
    if (ad_ph == 2) ad_res[31:16] <= ad_sum[31:16];
    if (smp_v) begin
      ad_a  <= smp_a;
      ad_b  <= smp_b;
      ad_ph <= 1;
    end else if (ad_ph == 1) ad_ph <= 2;
    else if (ad_ph == 2) ad_ph <= 0;
  end

  // Reference model: issue allowed once drained and 3 cycles past the last
  // issue; every accepted op answers 4 cycles later unless a reset intervenes.
  typedef struct {int due; int id; logic [31:0] sum;} exp_t;
  exp_t        pend[$];
  exp_t        e;
  int          m_rr = 0, m_last = -100, m_drain = 0, last_av_cyc = -100, g, r;
  bit          m_init = 1'b0;
  logic [N-1:0]  m_rv = '0, e_rdy;
  logic [31:0]   m_res = '0, ea, eb;
  logic [IW-1:0] m_rid = '0;

  always @(negedge clk) begin
    e_rdy = '0; ea = '0; eb = '0; g = -1;
    if (!rst && m_drain == 0 && (cyc - m_last) >= int'(ADD_ISSUE_INTERVAL))
      for (int i = 0; i < int'(N); i++) begin
        r = (m_rr + i) % int'(N);
        if (g < 0 && bus.req_valid_i[r]) g = r;
      end
    if (g >= 0) begin
      e_rdy[g] = 1'b1;
      ea = bus.req_a_i[g];
      eb = bus.req_b_i[g];
    end
    chk("req_ready", 32'(bus.req_ready_o), 32'(e_rdy));
    chk("add_valid", 32'(bus.add_valid_o), 32'(g >= 0));
    chk("add_a", bus.add_a_o, ea);
    chk("add_b", bus.add_b_o, eb);
    if (bus.add_valid_o) begin
      chk("issue_spacing", 32'((cyc - last_av_cyc) >= 3), 32'(1));
      last_av_cyc = cyc;
    end
    if (m_init) begin
      chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(m_rv));
      chk("rsp_res", bus.rsp_res_o, m_res);
      chk("rsp_id", 32'(bus.rsp_id_o), 32'(m_rid));
      if (!rst)
        chk("busy", 32'(bus.busy_o),
            32'(m_drain > 0 || ((cyc - m_last) >= 1 && (cyc - m_last) <= int'(ADD_RESULT_LAT))));
    end
    if (rst) begin
      pend.delete();
      m_rr = 0; m_last = -100; m_drain = int'(DRAIN_CYCLES);
      m_rv = '0; m_res = '0; m_rid = '0; m_init = 1'b1;
    end else begin
      if (m_drain > 0) m_drain--;
      if (g >= 0) begin
        m_rr = (g + 1) % int'(N);
        m_last = cyc;
        pend.push_back('{due: cyc + int'(ADD_RESULT_LAT) + 1, id: g, sum: ea + eb});
      end
      m_rv = '0;
      if (pend.size() > 0 && pend[0].due == cyc + 1) begin
        e = pend.pop_front();
        m_rv[e.id] = 1'b1;
        m_res = e.sum;
        m_rid = IW'(e.id);
      end
    end
  end

  // Per-test logs of sampled outputs, indexed from the start of each test.
  logic [N-1:0]  g_log [64];
  logic          av_log[64];
  logic [N-1:0]  rv_log[64];
  logic [31:0]   res_log[64];
  logic [IW-1:0] id_log[64];
  logic [N-1:0]  last_g = '0;
  int            gk = 0;

  task automatic clr_log();
    gk = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (gk < 64) begin
      g_log[gk]   = bus.req_ready_o;
      av_log[gk]  = bus.add_valid_o;
      rv_log[gk]  = bus.rsp_valid_o;
      res_log[gk] = bus.rsp_res_o;
      id_log[gk]  = bus.rsp_id_o;
    end
    last_g = bus.req_ready_o;
    gk++;
    @(posedge clk);
    #1;
  endtask

  task automatic new_op(input int q);
    bus.req_valid_i[q] = 1'b1;
    bus.req_a_i[q] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
    bus.req_b_i[q] = ($urandom_range(0, 3) == 0) ? 32'h8000_0001 : $urandom;
  endtask

  task automatic one_op(input int q, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] s);
    logic [N-1:0] oh;
    oh = '0;
    oh[q] = 1'b1;
    clr_log();
    bus.req_valid_i[q] = 1'b1;
    bus.req_a_i[q] = a;
    bus.req_b_i[q] = b;
    tick();
    bus.req_valid_i[q] = 1'b0;
    repeat (4) tick();
    chk("lit_grant", 32'(g_log[0]), 32'(oh));
    chk("lit_add_valid", 32'(av_log[0]), 32'(1));
    chk("lit_rsp_valid", 32'(rv_log[4]), 32'(oh));
    chk("lit_rsp_res", res_log[4], s);
    chk("lit_rsp_id", 32'(id_log[4]), q);
  endtask

  initial begin
    bus.req_valid_i = '0;
    bus.req_a_i = '0;
    bus.req_b_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();

    one_op(0, 32'd5, 32'd7, 32'd12);
    one_op(1, 32'h0000_FFFF, 32'h1, 32'h0001_0000);
    one_op(2, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000);
    one_op(3, 32'h8000_FFFF, 32'h8000_FFFF, 32'h0001_FFFE);

    // All four requesters continuously valid.
    clr_log();
    for (int q = 0; q < int'(N); q++) new_op(q);
    for (int k = 0; k < 16; k++) begin
      tick();
      for (int q = 0; q < int'(N); q++) if (last_g[q]) new_op(q);
    end
    bus.req_valid_i = '0;
    repeat (6) tick();
    for (int i = 0; i < 5; i++) chk("rr_grant", 32'(g_log[3*i]), 32'(1) << (i % 4));
    for (int i = 0; i < 4; i++) begin
      chk("rr_rsp_valid", 32'(rv_log[3*i+4]), 32'(1) << i);
      chk("rr_rsp_id", 32'(id_log[3*i+4]), i);
    end

    // Requester 2 hogs, requester 1 arrives at cycle 4.
    clr_log();
    new_op(2);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) new_op(1);
      tick();
      if (last_g[2]) new_op(2);
      if (last_g[1]) bus.req_valid_i[1] = 1'b0;
    end
    bus.req_valid_i = '0;
    repeat (6) tick();
    chk("hog_grant0", 32'(g_log[0]), 32'h4);
    chk("hog_grant3", 32'(g_log[3]), 32'h4);
    chk("hog_grant6", 32'(g_log[6]), 32'h2);

    // Requester 3 shows up only during WAIT2 and withdraws.
    clr_log();
    new_op(0);
    tick();
    bus.req_valid_i[0] = 1'b0;
    tick();
    new_op(3);
    tick();
    bus.req_valid_i[3] = 1'b0;
    new_op(0);
    new_op(2);
    tick();
    bus.req_valid_i = '0;
    repeat (6) tick();
    chk("wd_grant0", 32'(g_log[0]), 32'h1);
    chk("wd_grant3", 32'(g_log[3]), 32'h4);

    // Reset during WAIT1 abandons the op; next op after drain completes.
    clr_log();
    new_op(0);
    tick();
    bus.req_valid_i[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid_i[1] = 1'b1;
    bus.req_a_i[1] = 32'd100;
    bus.req_b_i[1] = 32'd23;
    for (int k = 2; k < 10; k++) begin
      tick();
      if (last_g[1]) bus.req_valid_i[1] = 1'b0;
    end
    for (int k = 2; k < 5; k++) chk("rst_no_issue", 32'(av_log[k]), 32'(0));
    chk("rst_no_rsp", 32'(rv_log[4]), 32'(0));
    chk("rst_grant", 32'(g_log[5]), 32'h2);
    chk("rst_rsp_valid", 32'(rv_log[9]), 32'h2);
    chk("rst_rsp_res", res_log[9], 32'd123);
    chk("rst_rsp_id", 32'(id_log[9]), 32'd1);

    // Random traffic with withdrawals and occasional resets.
    for (int k = 0; k < 600; k++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
      for (int q = 0; q < int'(N); q++) begin
        if (last_g[q]) begin
          if ($urandom_range(0, 1) == 0) new_op(q);
          else bus.req_valid_i[q] = 1'b0;
        end else if (!bus.req_valid_i[q]) begin
          if ($urandom_range(0, 3) == 0) new_op(q);
        end else if ($urandom_range(0, 15) == 0) begin
          bus.req_valid_i[q] = 1'b0;
        end
      end
    end
    rst = 1'b0;
    bus.req_valid_i = '0;
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adder_share_ctrl.md
# adder_share_ctrl

Time-multiplexes the measure unit's single `two_cycle_32_adder` between `N_REQ` requesters. Arbitration is round-robin, and only one addition is in flight at a time, because the adder's operand registers must not change while it is busy. The block issues one operation per 3 cycles, captures the completed 32-bit sum, and returns it with the requester ID. It sits between the measure-unit consumers (timestamp accumulators, offset correction) and the adder instance.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..8.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester ID.

- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_valid_i` in `[N_REQ]`: per-requester request valid.
- `req_a_i`, `req_b_i` in `[N_REQ][32]`: operands. Must be held stable while valid until accepted.
- `req_ready_o` out `[N_REQ]`: one-hot accept. High only for the granted requester in an issue cycle.
- `add_valid_o` out 1: drives the adder's `valid_i`.
- `add_a_o`, `add_b_o` out 32: drive the adder's `a_i`/`b_i`. Equal to the granted operands in the issue cycle, 0 otherwise.
- `add_res_i` in 32: from the adder's `res_o`.
- `rsp_valid_o` out `[N_REQ]`: one-hot, one-cycle result pulse.
- `rsp_res_o` out 32: registered sum. Holds its value between pulses.
- `rsp_id_o` out `ID_W`: index of the requester that owns `rsp_res_o`.
- `busy_o` out 1: high in any state other than IDLE.

## Operation
- **FSM states:** DRAIN, IDLE, WAIT1, WAIT2, COLLECT.
- **Issue:** allowed only in IDLE or COLLECT, and only when at least one `req_valid_i` is high.
  - The round-robin arbiter picks the first valid requester at or after `rr_ptr`, wrapping at `N_REQ`.
  - The block asserts `req_ready_o[g]` and `add_valid_o`, and muxes the operands onto `add_a_o`/`add_b_o`.
  - It latches `g` into `cur_id` and sets `rr_ptr <= (g+1) mod N_REQ`.
- **Transitions:**
  - IDLE goes to WAIT1 on issue; otherwise it stays in IDLE.
  - WAIT1 always goes to WAIT2.
  - WAIT2 always goes to COLLECT.
  - COLLECT goes to WAIT1 on issue; otherwise it goes to IDLE.
- **Result capture in COLLECT:** the adder's upper half is final in this cycle. At the end of the cycle:
  - `rsp_res_o <= add_res_i`
  - `rsp_id_o <= cur_id`
  - `rsp_valid_o <= onehot(cur_id)` for exactly one cycle.
- **Adder `valid_o` is ignored.** It asserts one cycle before the upper half is written, so completion is tracked by the fixed schedule only.
- **No backpressure on responses:** consumers must sample the result during the `rsp_valid_o` pulse.
- **Arithmetic:** modulo 2^32. Carry out of bit 31 is discarded.
- **Reset values:**
  - state = DRAIN, `drain_cnt` = 3, `rr_ptr` = 0, `cur_id` = 0.
  - `rsp_valid_o` = 0, `rsp_res_o` = 0, `rsp_id_o` = 0.
  - `add_valid_o` = 0, `req_ready_o` = 0.
- **DRAIN:** `drain_cnt` decrements each cycle. The FSM enters IDLE when the counter reaches 0, and no issue happens in DRAIN. This lets an adder with no reset finish any operation that was interrupted by reset.
- **Reset mid-operation:** the in-flight operation is abandoned and no `rsp_valid_o` is produced for it. The requester has already seen ready, so it does not retry automatically.
- **`req_valid_i` deasserted before grant:** legal. The request is never accepted and `rr_ptr` does not change.

## Timing
- **Issue to response:** a request accepted in cycle t has `rsp_valid_o` high in cycle t+4.
- **Adder schedule after issue at t:**
  - operands latched at the edge ending cycle t;
  - low half written at the end of t+1;
  - high half written at the end of t+2;
  - full sum visible on `add_res_i` during t+3 (COLLECT).
- **Throughput:** one issue every 3 cycles at most.
  - `add_valid_o` is never high in two issue cycles closer than 3 apart.
  - It is never high in WAIT1, WAIT2 or DRAIN.
- **Combinational paths:** `req_ready_o` and `add_*_o` are combinational from `req_valid_i`, `rr_ptr` and state. No other combinational paths.
- **First issue after `rst_i` falls:** no earlier than the 4th cycle after the last reset cycle.

## Structure
- **Package `mu_pkg`:**
  - state enum `share_state_e`;
  - `ADD_ISSUE_INTERVAL = 3`, `ADD_RESULT_LAT = 3` (cycles from issue to COLLECT);
  - `ADD_W = 32`;
  - `DRAIN_CYCLES = 3`.
- **Sub-module `rr_arbiter`:** parameterised by `N`. Inputs are the request vector, the pointer and an enable; outputs are the one-hot grant and the encoded index.
- **Adder:** instantiated by the parent level. This block only drives its ports.

## Test plan
- **Single request:** `req_valid_i[0]` with a=5, b=7 at cycle 0 after drain → `req_ready_o[0]` and `add_valid_o` in cycle 0; `rsp_valid_o=0001`, `rsp_res_o=12`, `rsp_id_o=0` in cycle 4.
- **Carry and wrap:**
  - a=0x0000FFFF, b=0x1 → 0x00010000;
  - a=0xFFFFFFFF, b=0x1 → 0x00000000;
  - a=0x8000FFFF, b=0x8000FFFF → 0x0001FFFE.
- **Round-robin:** all 4 requesters continuously valid → grants 0,1,2,3,0 in cycles 0,3,6,9,12; responses with ids 0,1,2,3 in cycles 4,7,10,13, each with the correct sum.
- **Single hog with late arrival:** requester 2 always valid, requester 1 asserted at cycle 4 → grants 2 (cycle 0), 2 (cycle 3), 1 (cycle 6). Scoreboard checks no `add_valid_o` spacing below 3.
- **Reset mid-operation:** assert `rst_i` in WAIT1 for 1 cycle → no `rsp_valid_o` for that op; `add_valid_o` low for 3 cycles after release; a following request a=100, b=23 returns 123 with the correct id.
- **Withdrawn request:** requester 3 valid only during a WAIT2 cycle → never granted; `rr_ptr` unchanged; next grant goes to the next valid requester.
